// File: rtl/addrreg_ctrl_pkg.sv
// addrreg_ctrl_pkg
// Shared definitions for the 16-bit address register controller and its
// requester models: op codes, controller state encoding and a helper that
// converts a cycle count into a down-counter preload value.
package addrreg_ctrl_pkg;

    // Requester op codes (OP0 / OP1)
    localparam logic [1:0] OP_ASSERT = 2'b00;
    localparam logic [1:0] OP_LOAD   = 2'b01;
    localparam logic [1:0] OP_INC    = 2'b10;
    localparam logic [1:0] OP_DEC    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PULSE  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_ASSERT = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    // The timer counts down to zero, so an N-cycle state preloads N-1.
    function automatic logic [3:0] cyc_preload(input int unsigned n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/addrreg_ctrl_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. Grant is combinational from the requests and
// the priority pointer; the pointer moves only when the owner strobes update,
// so a request that is not actually taken does not disturb fairness.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req0, req1  request inputs
//   update      pointer update strobe (grant accepted this cycle)
//   gnt         one-hot grant, bit 0 = requester 0, bit 1 = requester 1
module rr_arb2
    import addrreg_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       update,
    output logic [1:0] gnt
);

    // Set when requester 1 should win the next tie.
    logic favour1;

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = favour1 ? 2'b10 : 2'b01;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour1 <= 1'b0;
        end else if (update) begin
            // whoever just won loses the next tie
            favour1 <= gnt[0];
        end
    end

endmodule

// File: rtl/addrreg_ctrl.sv
// addrreg_ctrl
// Sequencer and two-way arbiter for a 16-bit address register built from
// cascaded 74193 up/down counters with 74541 bus drivers. One transaction at a
// time; every control line is held for its programmed width and the counter
// ripple is given time to settle before the requester sees DONE.
//
// Ports:
//   CLK, RST_bar        clock, asynchronous active-low reset
//   REQ0/REQ1, OP0/OP1  requests and op codes (00 assert, 01 load, 10 inc, 11 dec)
//   GNT0/GNT1           high for the whole granted transaction
//   DONE0/DONE1         one-cycle completion strobe (last cycle of the grant)
//   ADDR_RST            register master reset, active high, follows RST_bar
//   ADDR_INC/ADDR_DEC   count-up/count-down clocks, idle high, count on rise
//   ADDR_LOAD_bar       parallel load, active low
//   ADDR_ASSERT_bar     bus output enable, active low
//   BUSY                high whenever the sequencer is not idle
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | lines idle, arbitrate on every edge
// ST_PULSE  | ADDR_INC or ADDR_DEC low; the release edge is the count
// ST_LOAD   | ADDR_LOAD_bar low; requester holds the bus value
// ST_ASSERT | ADDR_ASSERT_bar low; DONE on the last cycle, no settle
// ST_SETTLE | lines idle for ripple/propagation; DONE on the last cycle
module addrreg_ctrl
    import addrreg_ctrl_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES  = 1,
    parameter int unsigned LOAD_CYCLES   = 1,
    parameter int unsigned ASSERT_CYCLES = 1,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST_bar,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [1:0] OP0,
    input  logic [1:0] OP1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       DONE0,
    output logic       DONE1,
    output logic       ADDR_RST,
    output logic       ADDR_INC,
    output logic       ADDR_DEC,
    output logic       ADDR_LOAD_bar,
    output logic       ADDR_ASSERT_bar,
    output logic       BUSY
);

    localparam logic [3:0] PULSE_PRE  = cyc_preload(PULSE_CYCLES);
    localparam logic [3:0] LOAD_PRE   = cyc_preload(LOAD_CYCLES);
    localparam logic [3:0] ASSERT_PRE = cyc_preload(ASSERT_CYCLES);
    localparam logic [3:0] SETTLE_PRE = cyc_preload(SETTLE_CYCLES);

    state_t     state;
    logic [3:0] cnt;
    logic       sel1;        // transaction in flight belongs to requester 1
    logic [1:0] arb_gnt;
    logic       arb_update;
    logic [1:0] op_sel;

    // The register clears whenever the controller is in reset; a count line
    // snapping high at that moment is dominated by MR.
    assign ADDR_RST = ~RST_bar;

    assign arb_update = (state == ST_IDLE) && (arb_gnt != 2'b00);
    assign op_sel     = arb_gnt[1] ? OP1 : OP0;

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst_n  (RST_bar),
        .req0   (REQ0),
        .req1   (REQ1),
        .update (arb_update),
        .gnt    (arb_gnt)
    );

    // Outputs are registered from the next state, so DONE is raised on the
    // edge that enters the final cycle of ASSERT or SETTLE.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            state           <= ST_IDLE;
            cnt             <= 4'd0;
            sel1            <= 1'b0;
            GNT0            <= 1'b0;
            GNT1            <= 1'b0;
            DONE0           <= 1'b0;
            DONE1           <= 1'b0;
            ADDR_INC        <= 1'b1;
            ADDR_DEC        <= 1'b1;
            ADDR_LOAD_bar   <= 1'b1;
            ADDR_ASSERT_bar <= 1'b1;
            BUSY            <= 1'b0;
        end else begin
            DONE0 <= 1'b0;
            DONE1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_update) begin
                        sel1 <= arb_gnt[1];
                        GNT0 <= arb_gnt[0];
                        GNT1 <= arb_gnt[1];
                        BUSY <= 1'b1;
                        case (op_sel)
                            OP_INC: begin
                                state    <= ST_PULSE;
                                cnt      <= PULSE_PRE;
                                ADDR_INC <= 1'b0;
                            end
                            OP_DEC: begin
                                state    <= ST_PULSE;
                                cnt      <= PULSE_PRE;
                                ADDR_DEC <= 1'b0;
                            end
                            OP_LOAD: begin
                                state         <= ST_LOAD;
                                cnt           <= LOAD_PRE;
                                ADDR_LOAD_bar <= 1'b0;
                            end
                            default: begin
                                state           <= ST_ASSERT;
                                cnt             <= ASSERT_PRE;
                                ADDR_ASSERT_bar <= 1'b0;
                                if (ASSERT_PRE == 4'd0) begin
                                    DONE0 <= arb_gnt[0];
                                    DONE1 <= arb_gnt[1];
                                end
                            end
                        endcase
                    end
                end

                ST_PULSE, ST_LOAD: begin
                    if (cnt == 4'd0) begin
                        state         <= ST_SETTLE;
                        cnt           <= SETTLE_PRE;
                        ADDR_INC      <= 1'b1;
                        ADDR_DEC      <= 1'b1;
                        ADDR_LOAD_bar <= 1'b1;
                        if (SETTLE_PRE == 4'd0) begin
                            DONE0 <= ~sel1;
                            DONE1 <= sel1;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                ST_ASSERT, ST_SETTLE: begin
                    if (cnt == 4'd0) begin
                        state           <= ST_IDLE;
                        GNT0            <= 1'b0;
                        GNT1            <= 1'b0;
                        ADDR_ASSERT_bar <= 1'b1;
                        BUSY            <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            DONE0 <= ~sel1;
                            DONE1 <= sel1;
                        end
                    end
                end

                default: begin
                    state           <= ST_IDLE;
                    GNT0            <= 1'b0;
                    GNT1            <= 1'b0;
                    ADDR_INC        <= 1'b1;
                    ADDR_DEC        <= 1'b1;
                    ADDR_LOAD_bar   <= 1'b1;
                    ADDR_ASSERT_bar <= 1'b1;
                    BUSY            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addrreg_ctrl.sv
// tb_addrreg_ctrl
// Bench for addrreg_ctrl: a behavioural 74193-style register fed by the
// control lines, a table of single transactions, directed multi-cycle
// sequences, and a randomized phase against a transaction-offset model.
module tb_addrreg_ctrl;
    import addrreg_ctrl_pkg::*;

    // model timing for the default-parameter instance
    localparam int P_C = 1;
    localparam int L_C = 1;
    localparam int A_C = 1;
    localparam int S_C = 2;

    logic       CLK = 1'b0;
    logic       RST_bar = 1'b1;
    logic       REQ0 = 1'b0, REQ1 = 1'b0;
    logic [1:0] OP0 = 2'b00, OP1 = 2'b00;
    logic GNT0, GNT1, DONE0, DONE1, ADDR_RST, ADDR_INC, ADDR_DEC;
    logic ADDR_LOAD_bar, ADDR_ASSERT_bar, BUSY;

    logic       REQ0_p = 1'b0, REQ1_p = 1'b0;
    logic [1:0] OP0_p = 2'b00, OP1_p = 2'b00;
    logic GNT0_p, GNT1_p, DONE0_p, DONE1_p, ADDR_RST_p, ADDR_INC_p, ADDR_DEC_p;
    logic ADDR_LOAD_bar_p, ADDR_ASSERT_bar_p, BUSY_p;

    int checks = 0;
    int errors = 0;
    logic mon_on = 1'b0;

    always #5 CLK = ~CLK;

    addrreg_ctrl dut (
        .CLK(CLK), .RST_bar(RST_bar), .REQ0(REQ0), .REQ1(REQ1), .OP0(OP0), .OP1(OP1),
        .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1), .ADDR_RST(ADDR_RST),
        .ADDR_INC(ADDR_INC), .ADDR_DEC(ADDR_DEC), .ADDR_LOAD_bar(ADDR_LOAD_bar),
        .ADDR_ASSERT_bar(ADDR_ASSERT_bar), .BUSY(BUSY)
    );

    addrreg_ctrl #(.PULSE_CYCLES(3), .LOAD_CYCLES(1), .ASSERT_CYCLES(1), .SETTLE_CYCLES(4)) dut_p (
        .CLK(CLK), .RST_bar(RST_bar), .REQ0(REQ0_p), .REQ1(REQ1_p), .OP0(OP0_p), .OP1(OP1_p),
        .GNT0(GNT0_p), .GNT1(GNT1_p), .DONE0(DONE0_p), .DONE1(DONE1_p), .ADDR_RST(ADDR_RST_p),
        .ADDR_INC(ADDR_INC_p), .ADDR_DEC(ADDR_DEC_p), .ADDR_LOAD_bar(ADDR_LOAD_bar_p),
        .ADDR_ASSERT_bar(ADDR_ASSERT_bar_p), .BUSY(BUSY_p)
    );

    // behavioural 16-bit register: counts on rising count clocks, MR dominates
    logic [15:0] reg_q = 16'h0000;
    logic [15:0] bus_in = 16'h0000;
    logic [15:0] bus_out;
    logic        bus_drv;
    logic        p_inc = 1'b1, p_dec = 1'b1;

    always @(ADDR_INC or ADDR_DEC or ADDR_RST or ADDR_LOAD_bar or bus_in) begin
        if (ADDR_RST) reg_q = 16'h0000;
        else if (!ADDR_LOAD_bar) reg_q = bus_in;
        else begin
            if (ADDR_INC && !p_inc) reg_q = reg_q + 16'd1;
            if (ADDR_DEC && !p_dec) reg_q = reg_q - 16'd1;
        end
        p_inc = ADDR_INC;
        p_dec = ADDR_DEC;
    end

    assign bus_drv = !ADDR_ASSERT_bar;
    assign bus_out = bus_drv ? reg_q : 16'h0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // invariants on both instances, every cycle
    always @(negedge CLK) begin
        if (mon_on) begin
            chk("invariants", {28'd0,
                (!ADDR_INC && !ADDR_DEC) || (!ADDR_INC_p && !ADDR_DEC_p),
                ((32'(!ADDR_INC) + 32'(!ADDR_DEC) + 32'(!ADDR_LOAD_bar) + 32'(!ADDR_ASSERT_bar)) > 1),
                ((32'(!ADDR_INC_p) + 32'(!ADDR_DEC_p) + 32'(!ADDR_LOAD_bar_p) + 32'(!ADDR_ASSERT_bar_p)) > 1),
                (GNT0 && GNT1) || (GNT0_p && GNT1_p) || (DONE0_p && DONE1_p)}, 32'd0);
        end
    end

    function automatic logic [9:0] out_vec();
        return {GNT0, GNT1, DONE0, DONE1, ADDR_RST, ADDR_INC, ADDR_DEC,
                ADDR_LOAD_bar, ADDR_ASSERT_bar, BUSY};
    endfunction

    localparam logic [9:0] RESET_VEC = 10'b0000_1_1111_0;

    task automatic do_reset();
        @(negedge CLK);
        REQ0 = 1'b0; REQ1 = 1'b0; REQ0_p = 1'b0;
        RST_bar = 1'b0;
        #1;
        chk("reset_outputs", {22'd0, out_vec()}, {22'd0, RESET_VEC});
        @(negedge CLK);
        RST_bar = 1'b1;
    endtask

    // drive one request set at a negedge and observe until DONE
    task automatic run_txn(input logic r0, input logic [1:0] o0, input logic r1,
                           input logic [1:0] o1, input logic [15:0] bv,
                           output int who, output int lows, output int done_cyc);
        int n_inc, n_dec, n_ld, n_as;
        @(negedge CLK);
        REQ0 = r0; OP0 = o0; REQ1 = r1; OP1 = o1; bus_in = bv;
        who = -1; done_cyc = 0;
        n_inc = 0; n_dec = 0; n_ld = 0; n_as = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge CLK);
            if (GNT0) who = 0;
            else if (GNT1) who = 1;
            if (!ADDR_INC) n_inc++;
            if (!ADDR_DEC) n_dec++;
            if (!ADDR_LOAD_bar) n_ld++;
            if (!ADDR_ASSERT_bar) n_as++;
            if (DONE0 || DONE1) begin
                done_cyc = c;
                REQ0 = 1'b0;
                REQ1 = 1'b0;
            end
        end
        lows = (n_inc << 24) | (n_dec << 16) | (n_ld << 8) | n_as;
        @(negedge CLK);
        chk("idle_after_done", {29'd0, BUSY, GNT0, GNT1}, 32'd0);
    endtask

    typedef struct {
        logic       r0;
        logic [1:0] o0;
        logic       r1;
        logic [1:0] o1;
        int         who;
        int         lows;   // {inc, dec, load, assert} low-cycle counts, one byte each
        int         done;
    } vec_t;

    vec_t vt[8];

    // transaction-offset reference model for the random phase
    int         m_act = 0, m_who = 0, m_k = 0, m_total = 0, m_last = 1;
    logic [1:0] m_op = 2'b00;

    function automatic int dur(input logic [1:0] op);
        if (op == OP_INC || op == OP_DEC) return P_C + S_C;
        if (op == OP_LOAD) return L_C + S_C;
        return A_C;
    endfunction

    task automatic model_edge();
        if (m_act != 0) begin
            if (m_k == m_total) m_act = 0;
            else m_k++;
        end else if (REQ0 || REQ1) begin
            if (REQ0 && REQ1) m_who = (m_last == 0) ? 1 : 0;
            else m_who = REQ0 ? 0 : 1;
            m_last  = m_who;
            m_op    = (m_who == 1) ? OP1 : OP0;
            m_k     = 1;
            m_total = dur(m_op);
            m_act   = 1;
        end
    endtask

    function automatic logic [8:0] model_vec();
        logic a;
        a = (m_act != 0);
        return {a && m_who == 0, a && m_who == 1,
                a && m_k == m_total && m_who == 0, a && m_k == m_total && m_who == 1,
                !(a && m_op == OP_INC && m_k <= P_C),
                !(a && m_op == OP_DEC && m_k <= P_C),
                !(a && m_op == OP_LOAD && m_k <= L_C),
                !(a && m_op == OP_ASSERT && m_k <= A_C),
                a};
    endfunction

    initial begin
        int who, lows, dcyc, ndone, order, n_low;
        logic g0, g1, d0, d1;

        vt[0] = '{1'b1, OP_INC,    1'b0, OP_ASSERT, 0, 32'h01000000, 3};
        vt[1] = '{1'b0, OP_ASSERT, 1'b1, OP_LOAD,   1, 32'h00000100, 3};
        vt[2] = '{1'b1, OP_DEC,    1'b1, OP_ASSERT, 0, 32'h00010000, 3};
        vt[3] = '{1'b1, OP_INC,    1'b1, OP_ASSERT, 1, 32'h00000001, 1};
        vt[4] = '{1'b0, OP_INC,    1'b1, OP_DEC,    1, 32'h00010000, 3};
        vt[5] = '{1'b1, OP_ASSERT, 1'b1, OP_LOAD,   0, 32'h00000001, 1};
        vt[6] = '{1'b1, OP_LOAD,   1'b0, OP_INC,    0, 32'h00000100, 3};
        vt[7] = '{1'b1, OP_INC,    1'b1, OP_INC,    1, 32'h01000000, 3};

        #2;
        do_reset();
        mon_on = 1'b1;

        // table of single transactions; arbitration pointer carries between rows
        for (int i = 0; i < 8; i++) begin
            run_txn(vt[i].r0, vt[i].o0, vt[i].r1, vt[i].o1, 16'h0000, who, lows, dcyc);
            chk($sformatf("vec%0d_grant", i), who, vt[i].who);
            chk($sformatf("vec%0d_lows", i), lows, vt[i].lows);
            chk($sformatf("vec%0d_done_cycle", i), dcyc, vt[i].done);
        end

        // load 0x00FF then increment across the byte boundary
        do_reset();
        run_txn(1'b0, OP_ASSERT, 1'b1, OP_LOAD, 16'h00FF, who, lows, dcyc);
        chk("load_00ff_reg", reg_q, 16'h00FF);
        run_txn(1'b1, OP_INC, 1'b0, OP_ASSERT, 16'h0000, who, lows, dcyc);
        chk("inc_reg_0100", reg_q, 16'h0100);
        chk("inc_done_cycle", dcyc, 3);

        // load 0x1234 then decrement
        run_txn(1'b0, OP_ASSERT, 1'b1, OP_LOAD, 16'h1234, who, lows, dcyc);
        chk("load_1234_reg", reg_q, 16'h1234);
        chk("load_done_cycle", dcyc, 3);
        run_txn(1'b0, OP_ASSERT, 1'b1, OP_DEC, 16'h0000, who, lows, dcyc);
        chk("dec_reg_1233", reg_q, 16'h1233);

        // both increment, held: grants alternate starting with requester 0
        do_reset();
        @(negedge CLK);
        REQ0 = 1'b1; OP0 = OP_INC; REQ1 = 1'b1; OP1 = OP_INC;
        ndone = 0; order = 0;
        for (int c = 0; c < 60 && ndone < 4; c++) begin
            @(negedge CLK);
            if (DONE0 || DONE1) begin
                if (DONE1) order = order | (1 << ndone);
                ndone++;
                if (ndone == 4) begin
                    REQ0 = 1'b0;
                    REQ1 = 1'b0;
                end
            end
        end
        chk("rr_done_count", ndone, 4);
        chk("rr_grant_order", order, 32'b1010);
        @(negedge CLK);
        @(negedge CLK);
        chk("rr_reg_plus4", reg_q, 16'h0004);

        // assert: bus driven for exactly the one ASSERT cycle
        @(negedge CLK);
        REQ0 = 1'b1; OP0 = OP_ASSERT;
        @(negedge CLK);
        chk("assert_cycle", {29'd0, ADDR_ASSERT_bar, bus_drv, DONE0}, 32'b011);
        chk("assert_bus_value", bus_out, 16'h0004);
        REQ0 = 1'b0;
        @(negedge CLK);
        chk("assert_released", {30'd0, ADDR_ASSERT_bar, bus_drv}, 32'b10);

        // reset during the dec pulse aborts and clears the register
        run_txn(1'b1, OP_LOAD, 1'b0, OP_ASSERT, 16'h0050, who, lows, dcyc);
        chk("preload_0050", reg_q, 16'h0050);
        @(negedge CLK);
        REQ1 = 1'b1; OP1 = OP_DEC;
        @(negedge CLK);
        chk("dec_pulse_low", {31'd0, ADDR_DEC}, 32'd0);
        #2;
        RST_bar = 1'b0;
        #1;
        chk("abort_outputs", {22'd0, out_vec()}, {22'd0, RESET_VEC});
        chk("abort_reg_zero", reg_q, 16'h0000);
        REQ1 = 1'b0;
        @(negedge CLK);
        RST_bar = 1'b1;
        run_txn(1'b0, OP_ASSERT, 1'b1, OP_INC, 16'h0000, who, lows, dcyc);
        chk("post_abort_grant", who, 1);
        chk("post_abort_done", dcyc, 3);
        chk("post_abort_reg", reg_q, 16'h0001);

        // long pulse / long settle instance
        @(negedge CLK);
        REQ0_p = 1'b1; OP0_p = OP_DEC;
        n_low = 0; dcyc = 0; g0 = 1'b0;
        for (int c = 1; c <= 20 && dcyc == 0; c++) begin
            @(negedge CLK);
            if (!ADDR_DEC_p) n_low++;
            if (c == 1) g0 = GNT0_p;
            if (DONE0_p) begin
                dcyc = c;
                REQ0_p = 1'b0;
            end
        end
        chk("param_dec_low_cycles", n_low, 3);
        chk("param_done_cycle", dcyc, 7);
        chk("param_grant", {31'd0, g0}, 32'd1);

        // randomized traffic against the offset model
        do_reset();
        m_act = 0; m_last = 1;
        for (int t = 0; t < 600; t++) begin
            @(posedge CLK);
            model_edge();
            @(negedge CLK);
            chk("random_cycle",
                {23'd0, GNT0, GNT1, DONE0, DONE1, ADDR_INC, ADDR_DEC, ADDR_LOAD_bar, ADDR_ASSERT_bar, BUSY},
                {23'd0, model_vec()});
            g0 = (m_act != 0) && m_who == 0;
            g1 = (m_act != 0) && m_who == 1;
            d0 = g0 && m_k == m_total;
            d1 = g1 && m_k == m_total;
            bus_in = 16'($urandom);
            if (d0) begin
                if ($urandom_range(1, 0) == 0) REQ0 = 1'b0;
                else OP0 = 2'($urandom_range(3, 0));
            end else if (g0) begin
                OP0 = 2'($urandom_range(3, 0));
                if ($urandom_range(9, 0) == 0) REQ0 = 1'b0;
            end else if (!REQ0 && $urandom_range(2, 0) == 0) begin
                REQ0 = 1'b1;
                OP0 = 2'($urandom_range(3, 0));
            end
            if (d1) begin
                if ($urandom_range(1, 0) == 0) REQ1 = 1'b0;
                else OP1 = 2'($urandom_range(3, 0));
            end else if (g1) begin
                OP1 = 2'($urandom_range(3, 0));
                if ($urandom_range(9, 0) == 0) REQ1 = 1'b0;
            end else if (!REQ1 && $urandom_range(2, 0) == 0) begin
                REQ1 = 1'b1;
                OP1 = 2'($urandom_range(3, 0));
            end
        end

        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
